// File: rtl/neuron_lut_loader.sv
// Runtime-loadable truth-table neuron: streamed DEPTH-entry table, then registered lookups.
// Lookup latency 1 cycle, 1 result/cycle; a load takes DEPTH handshakes minimum.
// cfg_ready low outside LOAD and on load_start; lookup path has no backpressure (requests outside READY are dropped).
module neuron_lut_loader #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [OUT_BITS-1:0] cfg_data,
  input  logic                cfg_last,
  output logic                lut_ready,
  output logic                load_err,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data
);

  localparam int DEPTH = 2 ** IN_BITS;
  localparam logic [IN_BITS-1:0] LAST_ADDR = {IN_BITS{1'b1}};

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IN_BITS-1:0]  wr_addr;
  logic [OUT_BITS-1:0] mem [DEPTH];
  logic                cfg_hs;
  logic                lkp_acc;
  logic                at_end;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next state: load_start always wins; a load ends on the last beat or on a framing error
  always_comb begin
    state_nxt = state;
    if (load_start) begin
      state_nxt = LOAD;
    end else if (state == LOAD && cfg_hs) begin
      if (cfg_last)    state_nxt = at_end ? READY : EMPTY;
      else if (at_end) state_nxt = EMPTY;
    end
  end

  // Combinational handshake / accept decode
  always_comb begin
    cfg_ready = (state == LOAD) && !load_start;
    cfg_hs    = cfg_valid && cfg_ready;
    lkp_acc   = in_valid && (state == READY) && !load_start;
    at_end    = (wr_addr == LAST_ADDR);
  end

  // Load bookkeeping: write pointer, sticky framing error, registered table-valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr   <= '0;
      load_err  <= 1'b0;
      lut_ready <= 1'b0;
    end else begin
      lut_ready <= (state_nxt == READY);
      if (load_start) begin
        wr_addr  <= '0;
        load_err <= 1'b0;
      end else if (cfg_hs) begin
        // counter may wrap here, but the state machine has already left LOAD
        wr_addr <= wr_addr + 1'b1;
        if (cfg_last != at_end) load_err <= 1'b1;
      end
    end
  end

  // Table storage: contents survive reset, only the valid flag is cleared
  always_ff @(posedge clk) begin
    if (cfg_hs) mem[wr_addr] <= cfg_data;
  end

  // Registered lookup; out_data holds its last value between results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= lkp_acc;
      if (lkp_acc) out_data <= mem[in_data];
    end
  end

endmodule

// File: tb/tb_neuron_lut_loader.sv
// Bench for neuron_lut_loader: scoreboard of expected lookup results against a table model.
// Results are checked 1 cycle after each accepted request; dropped requests must not produce results.
// Config beats wait (bounded) for cfg_ready; lookups are never backpressured.
module tb_neuron_lut_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_start;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_data;
  logic       cfg_last;
  logic       lut_ready;
  logic       load_err;
  logic       in_valid;
  logic [5:0] in_data;
  logic       out_valid;
  logic [1:0] out_data;

  int errors = 0;
  int checks = 0;
  int n_results = 0;
  int cyc;
  int base;

  logic [1:0] tbl   [64];
  logic [1:0] model [64];
  logic [1:0] sb [$];

  neuron_lut_loader #(.IN_BITS(6), .OUT_BITS(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .cfg_last   (cfg_last),
    .lut_ready  (lut_ready),
    .load_err   (load_err),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Stream tbl[0..nbeats-1]; cfg_last on beat last_at; optional idle cycle after each beat
  task automatic stream(input int nbeats, input int last_at, input bit toggle, output int cycles);
    bit got;
    cycles = 0;
    tick();
    for (int i = 0; i < nbeats; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = tbl[i];
      cfg_last  = (i == last_at);
      got = 1'b0;
      for (int w = 0; w < 8 && !got; w++) begin
        @(negedge clk);
        got = cfg_ready;
        tick();
        cycles++;
      end
      if (!got) begin
        chk("cfg_hs_timeout", 0, 1);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        return;
      end
      if (toggle) begin
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        tick();
        cycles++;
      end
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic lookup(input logic [5:0] a, input bit expect_ok);
    in_valid = 1'b1;
    in_data  = a;
    if (expect_ok) sb.push_back(model[a]);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_cfg_ready"}, int'(cfg_ready), 0);
    chk({pfx, "_lut_ready"}, int'(lut_ready), 0);
    chk({pfx, "_load_err"},  int'(load_err),  0);
    chk({pfx, "_out_valid"}, int'(out_valid), 0);
    chk({pfx, "_out_data"},  int'(out_data),  0);
  endtask

  // Scoreboard: every result must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      n_results++;
      if (sb.size() == 0) chk("spurious_out_valid", 1, 0);
      else                chk("out_data", int'(out_data), int'(sb.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; load_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    cfg_last = 1'b0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // Lookups before any table is loaded are dropped
    in_valid = 1'b1; in_data = 6'd50;
    repeat (3) tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("preload_lut_ready", int'(lut_ready), 0);
    chk("preload_out_valid", int'(out_valid), 0);

    // Full back-to-back load with three marked entries
    for (int i = 0; i < 64; i++) tbl[i] = 2'b00;
    tbl[2] = 2'b11; tbl[26] = 2'b01; tbl[50] = 2'b10;
    do_start();
    @(negedge clk);
    chk("start_cfg_ready", int'(cfg_ready), 1);
    chk("start_lut_ready", int'(lut_ready), 0);
    stream(64, 63, 1'b0, cyc);
    chk("b2b_cycles", cyc, 64);
    @(negedge clk);
    chk("b2b_lut_ready", int'(lut_ready), 1);
    chk("b2b_load_err",  int'(load_err),  0);
    chk("b2b_cfg_ready", int'(cfg_ready), 0);
    model = tbl;

    base = n_results;
    lookup(6'd50, 1'b1); lookup(6'd26, 1'b1); lookup(6'd2, 1'b1); lookup(6'd0, 1'b1);
    repeat (2) @(negedge clk);
    chk("burst_results", n_results - base, 4);

    // out_data holds between results
    lookup(6'd50, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    chk("hold_out_valid", int'(out_valid), 0);
    chk("hold_out_data",  int'(out_data),  int'(model[50]));

    // Throttled load: one beat every other cycle, then full readback
    for (int i = 0; i < 64; i++) tbl[i] = 2'($urandom_range(0, 3));
    do_start();
    stream(64, 63, 1'b1, cyc);
    chk("toggle_cycles", cyc, 128);
    @(negedge clk);
    chk("toggle_lut_ready", int'(lut_ready), 1);
    model = tbl;
    for (int a = 0; a < 64; a++) lookup(6'(a), 1'b1);
    repeat (2) tick();

    // Early cfg_last on beat 10
    do_start();
    stream(11, 10, 1'b0, cyc);
    @(negedge clk);
    chk("early_load_err",  int'(load_err),  1);
    chk("early_lut_ready", int'(lut_ready), 0);
    chk("early_cfg_ready", int'(cfg_ready), 0);
    lookup(6'd5, 1'b0); lookup(6'd6, 1'b0);

    // Missing cfg_last on beat 63
    do_start();
    @(negedge clk);
    chk("restart_load_err_clear", int'(load_err), 0);
    stream(64, -1, 1'b0, cyc);
    @(negedge clk);
    chk("nolast_load_err",  int'(load_err),  1);
    chk("nolast_lut_ready", int'(lut_ready), 0);
    chk("nolast_cfg_ready", int'(cfg_ready), 0);

    do_start();
    @(negedge clk);
    chk("restart2_load_err_clear", int'(load_err), 0);
    stream(64, 63, 1'b0, cyc);
    @(negedge clk);
    chk("reload_lut_ready", int'(lut_ready), 1);
    model = tbl;

    // Reload while READY: lookup the cycle before survives, same-cycle one is dropped
    lookup(6'd50, 1'b1);
    in_valid = 1'b1; in_data = 6'd26; load_start = 1'b1;
    tick();
    in_valid = 1'b0; load_start = 1'b0;
    @(negedge clk);
    chk("reload_lut_ready_fall", int'(lut_ready), 0);
    for (int i = 0; i < 64; i++) tbl[i] = 2'($urandom_range(0, 3));
    tbl[50] = 2'b01;
    stream(64, 63, 1'b0, cyc);
    @(negedge clk);
    chk("newtbl_lut_ready", int'(lut_ready), 1);
    model = tbl;
    lookup(6'd7, 1'b1); lookup(6'd50, 1'b1);
    repeat (2) tick();

    // Asynchronous reset in the middle of a load
    do_start();
    stream(20, -1, 1'b0, cyc);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midload_rst");
    @(negedge clk);
    rst_n = 1'b1;
    lookup(6'd50, 1'b0); lookup(6'd2, 1'b0);
    @(negedge clk);
    chk("postrst_lut_ready", int'(lut_ready), 0);
    chk("postrst_cfg_ready", int'(cfg_ready), 0);
    do_start();
    stream(64, 63, 1'b0, cyc);
    @(negedge clk);
    chk("postrst_reload_ready", int'(lut_ready), 1);
    model = tbl;
    lookup(6'd0, 1'b1); lookup(6'd50, 1'b1); lookup(6'd63, 1'b1);
    repeat (3) tick();
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
